mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Channel scanner sitting directly upstream of the 4:1 mux. It drives the mux select through a masked set of channels, holding each for a programmable dwell time. At the end of each dwell it samples the mux's 1-bit output, collecting one bit per channel into a 4-bit result register. A start/done handshake lets a controller trigger one full scan and read the collected bits.

## Interface
- `DWELL`, default 4: cycles each selected channel is held before sampling; legal range ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: scan request; sampled only in IDLE.
- `ch_mask` in 4: bit i = 1 means channel i is scanned; latched when start is accepted.
- `mux_out` in 1: mux output to be sampled.
- `sel` out 2: mux select.
- `busy` out 1: high while in SCAN or FIN.
- `done` out 1: one-cycle pulse at scan completion.
- `sample` out 4: bit i holds the value of `mux_out` captured while `sel` = i.

## Operation
- Reset values: state IDLE, `sel` = 0, `busy` = 0, `done` = 0, `sample` = 4'b0000, dwell counter = 0, latched mask = 0.
- FSM states are IDLE, SCAN and FIN.
- **IDLE**
  - `start` = 1 with `ch_mask` ≠ 0:
    - latch the mask;
    - clear `sample` to 0;
    - load `sel` with the lowest enabled channel;
    - clear the counter;
    - go to SCAN.
  - `start` = 1 with `ch_mask` = 0: clear `sample` and go directly to FIN (empty scan).
- **SCAN**
  - The counter increments each cycle.
  - On the edge where counter = DWELL-1:
    - write `sample[sel]` ← `mux_out`;
    - clear the counter;
    - move `sel` to the next higher enabled channel in the latched mask.
  - If there is no higher enabled channel, go to FIN instead. There is no wrap-around.
- **FIN**
  - `done` = 1 for exactly one cycle, then return to IDLE.
- Sample bits of disabled channels stay 0.
- `start` is ignored in SCAN and FIN. Changes to `ch_mask` after acceptance are ignored.
- `sel` = 0 in IDLE and FIN. It changes only on accept edges and capture edges.
- `sample` is stable from FIN until the next accepted start. Reading it when `done` is high is valid.
- Asserting `rst` mid-scan aborts immediately to reset values. No `done` is produced.

## Timing
- Accept edge = E0. `sel` for the first channel is valid from E0 to E0+DWELL.
- For k enabled channels:
  - the capture of channel j (0-based order) is at edge E0+(j+1)·DWELL;
  - the last capture is at E0+k·DWELL;
  - `done` is high in the cycle after edge E0+k·DWELL;
  - `busy` falls at edge E0+k·DWELL+1.
- Empty mask: `done` is high in the cycle after E0.
- Each channel gets exactly DWELL cycles of settling before `mux_out` is sampled. The mux is combinational, so no additional latency is assumed.
- DWELL = 1: `sel` advances every cycle and the counter stays at 0.
- Counter width is max(1, $clog2(DWELL)).

## Structure
- Package `mux_scan_pkg`:
  - `N_CH` = 4;
  - `SEL_W` = 2;
  - state enum `scan_state_t` {IDLE, SCAN, FIN}.
- Sub-module `mux_scan_next_ch`: combinational. It takes (mask, current sel) and returns the next higher enabled channel plus a `found` flag. Used in SCAN for advancing `sel`. The IDLE lowest-channel lookup is a call with current sel = -1, implemented as a "from 0 inclusive" input flag.
- The top level holds the FSM, counter, mask latch and sample register.

## Test plan
- Mux driven with in = 4'b1010, DWELL = 4, mask 4'b1111, start pulse:
  - `sel` is 0, 1, 2, 3, each for 4 cycles;
  - `sample` = 4'b1010;
  - `done` is one cycle, 16 edges after accept;
  - `busy` is high for 17 cycles.
- Same mux input, mask 4'b1010:
  - `sel` is 1 for 4 cycles, then 3 for 4 cycles;
  - `sample` = 4'b1010;
  - `done` is high after the 8th edge;
  - `sel` = 0 when IDLE.
- Mask 4'b0000 with start: `done` pulses in the next cycle, `sample` = 0, `sel` never leaves 0.
- DWELL = 1, mask 4'b0110, in = 4'b0100: `sel` is 1 then 2 on consecutive cycles, `sample` = 4'b0100, `done` follows 2 edges after accept.
- `start` re-pulsed mid-scan and `ch_mask` changed mid-scan: no effect on the sequence or the result; exactly one `done` is produced.
- `rst` asserted during the second channel's dwell: all outputs immediately return to reset values and no `done` is produced. A later start runs a full, correct scan.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared definitions for the mux channel scanner: channel count, select
// width and the scanner FSM state encoding.
package mux_scan_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FIN
    } scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch
// Combinational next-channel finder for the scanner.
// Ports:
//   mask      - enabled-channel mask (bit i = channel i enabled)
//   cur_sel   - channel currently selected
//   from_zero - search from channel 0 inclusive, ignoring cur_sel
//   next_sel  - lowest enabled channel above cur_sel (or >= 0 if from_zero)
//   found     - high when such a channel exists
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur_sel,
    input  logic             from_zero,
    output logic [SEL_W-1:0] next_sel,
    output logic             found
);

    // Walk from the top channel downwards so the last hit, which is the
    // lowest qualifying channel, is the one that sticks.
    always_comb begin
        next_sel = '0;
        found    = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_zero || (i > int'(cur_sel)))) begin
                next_sel = SEL_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Channel scanner driving a 4:1 mux select. Each enabled channel is held for
// DWELL cycles, then the mux output is captured into the matching bit of
// sample. One scan per accepted start; done pulses for one cycle at the end.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   start    - scan request, only looked at in IDLE
//   ch_mask  - channels to scan, latched when start is accepted
//   mux_out  - mux output being sampled
//   sel      - mux select (0 whenever not scanning)
//   busy     - high from accept until done has been shown
//   done     - one-cycle completion pulse
//   sample   - captured bit per channel, zero for disabled channels
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic             mux_out,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  sample
);

    // A DWELL of 1 still needs a one-bit counter that simply stays at zero.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [N_CH-1:0]  mask_q;

    logic [N_CH-1:0]  find_mask;
    logic             find_from_zero;
    logic [SEL_W-1:0] find_sel;
    logic             find_found;

    // In IDLE the finder looks at the live mask from channel 0 to pick the
    // first channel; during the scan it looks above sel in the latched mask.
    always_comb begin
        find_from_zero = (state == IDLE);
        find_mask      = (state == IDLE) ? ch_mask : mask_q;
    end

    mux_scan_next_ch u_next_ch (
        .mask      (find_mask),
        .cur_sel   (sel),
        .from_zero (find_from_zero),
        .next_sel  (find_sel),
        .found     (find_found)
    );

    // Scanner FSM with the dwell counter, mask latch and sample register.
    // An empty mask skips straight to FIN so the handshake still completes.
    // The last capture moves to FIN and parks sel at 0 in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sample <= '0;
            cnt    <= '0;
            mask_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sample <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        mask_q <= ch_mask;
                        if (ch_mask != '0) begin
                            sel   <= find_sel;
                            state <= SCAN;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                SCAN: begin
                    if (cnt == CNT_LAST) begin
                        sample[sel] <= mux_out;
                        cnt         <= '0;
                        if (find_found) begin
                            sel <= find_sel;
                        end else begin
                            sel   <= '0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
// Scoreboard bench for mux_scan_ctrl. Two scanners share one clock, reset,
// mask and mux input pattern: one with DWELL=4, one with DWELL=1. Each has
// its own start, and each drives its own model of the 4:1 mux.
module tb_mux_scan_ctrl;

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ch_mask = 4'b0000;
    logic [3:0] mux_in = 4'b0000;
    logic       start4 = 1'b0;
    logic       start1 = 1'b0;

    logic [1:0] sel4, sel1;
    logic       busy4, busy1, done4, done1;
    logic [3:0] sample4, sample1;
    logic       mux_out4, mux_out1;

    cyc_t       q4[$];
    cyc_t       q1[$];
    logic [3:0] r4[$];
    logic [3:0] r1[$];

    int total = 0;
    int bad   = 0;

    // Combinational 4:1 mux in front of each scanner.
    assign mux_out4 = mux_in[sel4];
    assign mux_out1 = mux_in[sel1];

    mux_scan_ctrl #(.DWELL(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .ch_mask (ch_mask),
        .mux_out (mux_out4),
        .sel     (sel4),
        .busy    (busy4),
        .done    (done4),
        .sample  (sample4)
    );

    mux_scan_ctrl #(.DWELL(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .ch_mask (ch_mask),
        .mux_out (mux_out1),
        .sel     (sel1),
        .busy    (busy1),
        .done    (done1),
        .sample  (sample1)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic setStart(input int d, input logic v);
        if (d == 0) start4 = v;
        else        start1 = v;
    endtask

    // Reference model: a scan visits the enabled channels in ascending
    // order, each for dwell cycles, then shows one done cycle. The result
    // is simply the mux input bits of the enabled channels.
    task automatic buildExp(input int d, input logic [3:0] mask, input logic [3:0] din);
        int   dw;
        cyc_t e;
        dw = (d == 0) ? 4 : 1;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                for (int t = 0; t < dw; t++) begin
                    e.sel  = 2'(c);
                    e.busy = 1'b1;
                    e.done = 1'b0;
                    if (d == 0) q4.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
        e.sel  = 2'd0;
        e.busy = 1'b1;
        e.done = 1'b1;
        if (d == 0) begin
            q4.push_back(e);
            r4.push_back(din & mask);
        end else begin
            q1.push_back(e);
            r1.push_back(din & mask);
        end
    endtask

    // Monitor step for one scanner: pop the expected cycle (idle when the
    // queue is empty) and, on done, pop and compare the expected result.
    task automatic monitorDut(input int d, input logic [1:0] s, input logic b,
                              input logic dn, input logic [3:0] smp);
        cyc_t       e;
        logic [3:0] er;
        logic       have;
        e    = '0;
        er   = 4'b0000;
        have = 1'b0;
        if (d == 0) begin
            if (q4.size() > 0) e = q4.pop_front();
        end else begin
            if (q1.size() > 0) e = q1.pop_front();
        end
        checkOutput((d == 0) ? "cycle_d4" : "cycle_d1", {28'd0, s, b, dn}, {28'd0, e});
        if (dn === 1'b1) begin
            if (d == 0 && r4.size() > 0) begin
                er = r4.pop_front();
                have = 1'b1;
            end else if (d == 1 && r1.size() > 0) begin
                er = r1.pop_front();
                have = 1'b1;
            end
            checkOutput((d == 0) ? "done_expected_d4" : "done_expected_d1", {31'd0, have}, 32'd1);
            checkOutput((d == 0) ? "sample_at_done_d4" : "sample_at_done_d1", {28'd0, smp}, {28'd0, er});
        end
    endtask

    // Monitor runs on the falling edge, away from the state updates.
    always @(negedge clk) begin
        monitorDut(0, sel4, busy4, done4, sample4);
        monitorDut(1, sel1, busy1, done1, sample1);
    end

    // Issue one scan on scanner d. Called just after a rising edge. With
    // noise set, start and ch_mask are scrambled while the scan runs, but
    // start is back at 0 before the scanner can return to IDLE.
    task automatic applyStimulus(input int d, input logic [3:0] mask, input logic [3:0] din, input bit noise);
        int k;
        int dw;
        dw = (d == 0) ? 4 : 1;
        k = 0;
        for (int c = 0; c < 4; c++) if (mask[c]) k++;
        mux_in  = din;
        ch_mask = mask;
        setStart(d, 1'b1);
        @(posedge clk);
        buildExp(d, mask, din);
        #1;
        setStart(d, (noise && k > 0) ? 1'($urandom) : 1'b0);
        if (noise) ch_mask = 4'($urandom);
        for (int m = 1; m <= k * dw; m++) begin
            @(posedge clk);
            #1;
            if (noise && m < k * dw) begin
                setStart(d, 1'($urandom));
                ch_mask = 4'($urandom);
            end else begin
                setStart(d, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("sample_hold", {28'd0, (d == 0) ? sample4 : sample1}, {28'd0, din & mask});
        checkOutput("queue_drained", (d == 0) ? q4.size() : q1.size(), 32'd0);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting mux_scan_ctrl bench");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_d4", {24'd0, sel4, busy4, done4, sample4}, 32'd0);
        checkOutput("reset_d1", {24'd0, sel1, busy1, done1, sample1}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases from the scanner's intended use.
        applyStimulus(0, 4'b1111, 4'b1010, 1'b0);
        applyStimulus(0, 4'b1010, 4'b1010, 1'b0);
        applyStimulus(0, 4'b0000, 4'b1010, 1'b0);
        applyStimulus(1, 4'b0110, 4'b0100, 1'b0);
        applyStimulus(1, 4'b0000, 4'b1111, 1'b0);
        applyStimulus(0, 4'b1111, 4'b0110, 1'b1);
        applyStimulus(1, 4'b1001, 4'b1001, 1'b1);

        // Reset during the second channel's dwell aborts the scan.
        mux_in  = 4'b1011;
        ch_mask = 4'b1111;
        start4  = 1'b1;
        @(posedge clk);
        buildExp(0, 4'b1111, 4'b1011);
        #1 start4 = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        q4.delete();
        r4.delete();
        checkOutput("abort_sel", {30'd0, sel4}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy4}, 32'd0);
        checkOutput("abort_done", {31'd0, done4}, 32'd0);
        checkOutput("abort_sample", {28'd0, sample4}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, 4'b1111, 4'b1011, 1'b0);

        // Randomized scans on either scanner.
        for (int n = 0; n < 16; n++) begin
            applyStimulus(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
